// File: rtl/muldiv_iter_unit.sv
// Iterative radix-2 multiply/divide unit for MULT/MULTU/DIV/DIVU on a start/ready handshake.
// One shift-add or restoring-subtract step per cycle; result is formatted for HI/LO write-back.
module muldiv_iter_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_mul_i,
  input  logic                signed_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  typedef enum logic [1:0] {StIdle, StByZero, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    counter_q, counter_d;
  logic                op_mul_q, op_mul_d;
  logic                signed_q, signed_d;
  logic                res_neg_q, res_neg_d;
  logic                rem_neg_q, rem_neg_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quot_q, quot_d;
  logic [2*DATA_W-1:0] result_q, result_d;

  logic [DATA_W-1:0]   mag1, mag2;
  logic [2*DATA_W-1:0] acc_step, prod_fix;
  logic [DATA_W:0]     rem_shift, rem_diff;
  logic [DATA_W-1:0]   rem_step, quot_step, rem_fix, quot_fix;
  logic                last_iter;

  assign mag1 = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign mag2 = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;

  // quot_q starts out holding the dividend; its MSB feeds the partial remainder each step.
  assign rem_shift = {rem_q, quot_q[DATA_W-1]};
  assign rem_diff  = rem_shift - {1'b0, divisor_q};
  assign rem_step  = rem_diff[DATA_W] ? rem_shift[DATA_W-1:0] : rem_diff[DATA_W-1:0];
  assign quot_step = {quot_q[DATA_W-2:0], ~rem_diff[DATA_W]};

  assign prod_fix = (signed_q && res_neg_q) ? -acc_step : acc_step;
  assign quot_fix = (signed_q && res_neg_q) ? -quot_step : quot_step;
  assign rem_fix  = (signed_q && rem_neg_q) ? -rem_step : rem_step;

  assign last_iter = (counter_q == CNT_W'(DATA_W - 1));

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    op_mul_d  = op_mul_q;
    signed_d  = signed_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    result_d  = '0;

    unique case (state_q)
      StIdle: begin
        if (start_i && !annul_i) begin
          state_d   = (!op_mul_i && opdata2_i == '0) ? StByZero : StBusy;
          counter_d = '0;
          op_mul_d  = op_mul_i;
          signed_d  = signed_i;
          res_neg_d = signed_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          rem_neg_d = signed_i & opdata1_i[DATA_W-1];
          mcand_d   = {{DATA_W{1'b0}}, mag1};
          mplier_d  = mag2;
          acc_d     = '0;
          divisor_d = mag2;
          rem_d     = '0;
          quot_d    = mag1;
        end
      end
      StByZero: begin
        state_d = annul_i ? StIdle : StDone;
      end
      StBusy: begin
        if (annul_i) begin
          state_d = StIdle;
        end else begin
          counter_d = counter_q + 1'b1;
          if (op_mul_q) begin
            acc_d    = acc_step;
            mcand_d  = {mcand_q[2*DATA_W-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[DATA_W-1:1]};
          end else begin
            rem_d  = rem_step;
            quot_d = quot_step;
          end
          if (last_iter) begin
            state_d  = StDone;
            result_d = op_mul_q ? prod_fix : {rem_fix, quot_fix};
          end
        end
      end
      StDone: begin
        if (annul_i || !start_i) begin
          state_d = StIdle;
        end else begin
          result_d = result_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      counter_q <= '0;
      op_mul_q  <= 1'b0;
      signed_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      op_mul_q  <= op_mul_d;
      signed_q  <= signed_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      result_q  <= result_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = (state_q == StDone);

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Scoreboard bench for muldiv_iter_unit: the driver queues expected results, a negedge monitor
// pops and compares them whenever ready_o rises.
module tb_muldiv_iter_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_mul, sgn, start, annul;
  logic [31:0] opdata1, opdata2;
  logic [63:0] result;
  logic        ready;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  bit seen = 1'b0;

  muldiv_iter_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_mul_i (op_mul),
    .signed_i (sgn),
    .opdata1_i(opdata1),
    .opdata2_i(opdata2),
    .start_i  (start),
    .annul_i  (annul),
    .result_o (result),
    .ready_o  (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: one comparison per ready_o rising, against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (ready && !seen) begin
      seen = 1'b1;
      if (exp_q.size() == 0) chk("unexpected_ready", 64'd1, 64'd0);
      else chk("result", result, exp_q.pop_front());
    end else if (!ready) begin
      seen = 1'b0;
    end
  end

  task automatic run_op(input bit mul, input bit s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_lat, input bit scramble,
                        input int hold);
    int lat = 0;
    exp_q.push_back(exp);
    @(negedge clk);
    op_mul = mul; sgn = s; opdata1 = a; opdata2 = b; start = 1'b1;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1 && scramble) begin
        opdata1 = $urandom; opdata2 = $urandom; sgn = 1'($urandom); op_mul = 1'($urandom);
      end
      if (ready || lat >= 100) break;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    if (!ready) void'(exp_q.pop_back());
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_ready", 64'(ready), 64'd1);
      chk("hold_result", result, exp);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("drop_ready", 64'(ready), 64'd0);
    chk("drop_result", result, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; annul = 1'b0; op_mul = 1'b0; sgn = 1'b0;
    opdata1 = '0; opdata2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, 0, 0);
    run_op(1, 1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 33, 1, 0);
    run_op(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 33, 0, 0);
    run_op(0, 1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1, 0);
    run_op(0, 1, 32'h0000_0007, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 0, 0);
    run_op(0, 0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E}, 33, 0, 0);
    run_op(0, 0, 32'd3, 32'd10, {32'h0000_0003, 32'h0000_0000}, 33, 0, 0);
    run_op(0, 0, 32'd5, 32'd0, 64'd0, 2, 0, 0);
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 33, 0, 0);

    // Annul in the 10th BUSY cycle, then an immediate new multiply.
    @(negedge clk);
    op_mul = 1'b1; sgn = 1'b0; opdata1 = 32'd123; opdata2 = 32'd456; start = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("annul_ready", 64'(ready), 64'd0);
    annul = 1'b0;
    run_op(1, 0, 32'd6, 32'd7, 64'h0000_0000_0000_002A, 33, 0, 0);

    // Annul together with start in IDLE must not be accepted.
    @(negedge clk);
    op_mul = 1'b0; opdata1 = 32'd5; opdata2 = 32'd0; start = 1'b1; annul = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("annul_idle_ready", 64'(ready), 64'd0);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;

    // Reset mid-BUSY.
    @(negedge clk);
    op_mul = 1'b1; sgn = 1'b0; opdata1 = 32'hFFFF_FFFF; opdata2 = 32'hFFFF_FFFF; start = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy_ready", 64'(ready), 64'd0);
    chk("rst_busy_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(1, 0, 32'h0001_0000, 32'h0001_0003, 64'h0000_0001_0003_0000, 33, 0, 3);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
- Multi-cycle arithmetic responder on the EX-stage start/ready handshake. It serves MULT, MULTU, DIV and DIVU.
- EX drives operands, the signed flag and start_i, and holds them (stalling the pipeline) until ready_o.
- The unit runs one radix-2 iteration per cycle: shift-add for multiply, restoring subtraction for divide.
- result_o is formatted for direct HI/LO write-back.

Parameters:
DATA_W, 32, operand width; result is 2*DATA_W; iteration count = DATA_W.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
op_mul_i  input  1  1 = multiply, 0 = divide; sampled at start acceptance
signed_i  input  1  1 = signed (MULT/DIV), 0 = unsigned; sampled at acceptance
opdata1_i  input  DATA_W  multiplicand / dividend
opdata2_i  input  DATA_W  multiplier / divisor
start_i  input  1  request; EX holds high while ready_o = 0
annul_i  input  1  abort current operation
result_o  output  2*DATA_W  mul: full product {hi, lo}; div: {remainder, quotient}
ready_o  output  1  result valid

Behaviour:
- Reset:
  - Synchronous rst forces state IDLE, ready_o = 0, result_o = 0, counter = 0 and clears internal registers.
  - rst mid-operation discards all work.
- States: IDLE, BYZERO, BUSY, DONE. ready_o = (state == DONE). result_o is registered, and is 0 in every state except DONE.
- IDLE:
  - Condition for acceptance: start_i = 1 and annul_i = 0 at an edge.
  - Divide with opdata2_i == 0: go to BYZERO.
  - Otherwise latch the operation and go to BUSY:
    - Latch op and signed flag.
    - Latch magnitudes: two's-complement absolute value when signed_i is set, raw value otherwise.
    - Latch sign flags: result sign = sign1 XOR sign2; remainder sign = sign1.
    - Set counter = 0.
- BYZERO: next edge goes to DONE with result_o = 0. ready_o is therefore visible after the 2nd edge counted from acceptance.
- BUSY multiply:
  - Each edge: if multiplier LSB = 1, acc += multiplicand (2*DATA_W).
  - Then multiplicand <<= 1 and multiplier >>= 1.
- BUSY divide:
  - Each edge: shift partial remainder left one bit, bringing in the dividend MSB.
  - Trial subtract the divisor (DATA_W+1 bits).
  - If non-negative, keep the difference and shift a 1 into the quotient; else shift in 0.
- Iteration count and latency:
  - counter increments each BUSY edge.
  - On the DATA_W-th BUSY edge (counter == DATA_W-1), go to DONE with the sign-corrected result latched into result_o.
  - Acceptance to ready_o = DATA_W + 1 edges (33 for the default).
- Sign correction applies to signed operations only:
  - Product is negated if the result sign is set.
  - Quotient is negated if the result sign is set.
  - Remainder is negated if the remainder sign is set.
  - Arithmetic is modulo 2^DATA_W. Signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0, with no trap.
- DONE:
  - result_o is held.
  - start_i = 0 goes to IDLE, so ready_o drops and result_o clears at that edge.
  - start_i = 1 stays in DONE, holding the result.
  - EX deasserts start_i in the ready cycle, so DONE nominally lasts 1 cycle.
- annul_i = 1 in BUSY, BYZERO or DONE: next edge goes to IDLE with ready_o = 0 and no result.
- annul_i and start_i both high in IDLE: the request is not accepted.
- Operand inputs are don't-care after acceptance; changing them mid-operation must not affect the result.
- Back-to-back: a new start is accepted on the first IDLE edge following DONE.

Test Plan:
- Unsigned mul, start=1, op_mul=1, signed=0, 0xFFFFFFFF x 0xFFFFFFFF -> ready_o rises after 33 edges; result_o = 0xFFFFFFFE_00000001.
- Signed mul -3 x 7 (0xFFFFFFFD, 0x00000007) -> result_o = 0xFFFFFFFF_FFFFFFEB; operands changed to random values after acceptance do not alter the result.
- Signed div -7 / 2 -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Unsigned div 100 / 7 -> result_o = {0x00000002, 0x0000000E}.
- Div by zero (opdata1=5, opdata2=0) -> ready_o after 2 edges; result_o = 0. Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
- annul_i pulsed at the 10th BUSY cycle -> IDLE next edge, ready_o never asserts. An immediate new unsigned mul 6 x 7 -> 0x00000000_0000002A after 33 edges.
- rst asserted mid-BUSY -> ready_o = 0 and result_o = 0 next edge. After release, start held in DONE keeps result stable; dropping start clears ready_o and result_o next edge.
